// File: rtl/risc_pkg.sv
// Shared encodings for the multi-cycle RV32I subset core: opcodes, funct fields,
// FSM states, ALU control codes, immediate formats and fault codes.
package risc_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluSlt
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ImmI, ImmS, ImmB
    } imm_src_e;

    typedef enum logic [1:0] {
        FaultNone    = 2'b00,
        FaultIllegal = 2'b01,
        FaultImem    = 2'b10,
        FaultDmem    = 2'b11
    } fault_e;

    // funct3 values shared by the register and immediate ALU groups
    function automatic logic f3_alu_legal(input logic [2:0] f3);
        return (f3 == F3_ADD_SUB) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    function automatic alu_ctrl_e f3_alu_op(input logic [2:0] f3);
        alu_ctrl_e op;
        case (f3)
            F3_SLT:  op = AluSlt;
            F3_OR:   op = AluOr;
            F3_AND:  op = AluAnd;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU: add, sub, and, or, signed set-less-than; wrap-around arithmetic.
module alu
    import risc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctrl_e   ctrl,
    output logic [31:0] result,
    output logic        zero
);

    // Select the operation result
    always_comb begin
        result = '0;
        case (ctrl)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'b0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control: state register, memory wait counter, instruction decode
// and every datapath strobe.
module mc_control_fsm
    import risc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        alu_zero,
    input  logic [1:0]  alu_lsbs,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        ab_we,
    output logic        aluout_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        pc_sel_branch,
    output logic        rf_we,
    output logic        wb_sel_mdr,
    output logic        alu_src_imm,
    output alu_ctrl_e   alu_ctrl,
    output imm_src_e    imm_src,
    output logic        retire,
    output logic        halt,
    output logic [1:0]  fault_code
);

    localparam int unsigned WaitW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    fault_e            fault_q, fault_d;

    logic      is_r, is_i, is_lw, is_sw, is_br, legal, taken;
    alu_ctrl_e op_alu;

    assign is_r  = (opcode == OPC_R);
    assign is_i  = (opcode == OPC_I);
    assign is_lw = (opcode == OPC_LOAD);
    assign is_sw = (opcode == OPC_STORE);
    assign is_br = (opcode == OPC_BRANCH);

    // Decode legality and ALU operation from the held instruction
    always_comb begin
        legal  = 1'b0;
        op_alu = AluAdd;
        case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE) begin
                    legal  = f3_alu_legal(funct3);
                    op_alu = f3_alu_op(funct3);
                end else if ((funct7 == F7_SUB) && (funct3 == F3_ADD_SUB)) begin
                    legal  = 1'b1;
                    op_alu = AluSub;
                end
            end
            OPC_I: begin
                legal  = f3_alu_legal(funct3);
                op_alu = f3_alu_op(funct3);
            end
            OPC_LOAD, OPC_STORE: legal = (funct3 == F3_WORD);
            OPC_BRANCH: begin
                if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                    legal  = 1'b1;
                    op_alu = AluSub;
                end else if (funct3 == F3_BLT) begin
                    legal  = 1'b1;
                    op_alu = AluSlt;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // Immediate format and branch outcome (blt uses the slt result bit)
    always_comb begin
        imm_src = ImmI;
        if (is_sw) begin
            imm_src = ImmS;
        end else if (is_br) begin
            imm_src = ImmB;
        end
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            default: taken = alu_lsbs[0];
        endcase
    end

    // State, wait counter and fault code registers
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= StFetch;
            wait_q  <= '0;
            fault_q <= FaultNone;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Next state and control strobes
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        fault_d       = fault_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        ab_we         = 1'b0;
        aluout_we     = 1'b0;
        mdr_we        = 1'b0;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        rf_we         = 1'b0;
        wb_sel_mdr    = 1'b0;
        alu_src_imm   = 1'b0;
        alu_ctrl      = AluAdd;
        retire        = 1'b0;
        halt          = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    wait_d  = '0;
                    state_d = StDecode;
                end else if (wait_q == WaitLast) begin
                    wait_d  = '0;
                    fault_d = FaultImem;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                if (legal) begin
                    ab_we   = 1'b1;
                    state_d = StExec;
                end else begin
                    fault_d = FaultIllegal;
                    state_d = StHalt;
                end
            end
            StExec: begin
                alu_ctrl    = op_alu;
                alu_src_imm = !(is_r || is_br);
                if (is_br) begin
                    pc_we         = 1'b1;
                    pc_sel_branch = taken;
                    retire        = 1'b1;
                    state_d       = StFetch;
                end else if (is_lw || is_sw) begin
                    // Misaligned addresses never reach the data bus
                    if (alu_lsbs != 2'b00) begin
                        fault_d = FaultIllegal;
                        state_d = StHalt;
                    end else begin
                        aluout_we = 1'b1;
                        state_d   = StMem;
                    end
                end else begin
                    aluout_we = 1'b1;
                    state_d   = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    wait_d = '0;
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    wait_d  = '0;
                    fault_d = FaultDmem;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb: begin
                rf_we      = 1'b1;
                wb_sel_mdr = is_lw;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StHalt: begin
                halt = 1'b1;
            end
            default: state_d = StHalt;
        endcase
        // Bus requests and status stay quiet while reset is held
        if (areset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
            halt     = 1'b0;
        end
        fault_code = areset ? FaultNone : fault_q;
    end

    // is_i only matters through op_alu; keep it visible for readability
    logic unused_is_i;
    assign unused_is_i = is_i;

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file, two combinational read ports, one write port; x0 reads zero.
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    // Clear everything on reset; writes to x0 are dropped so it stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/sign_extend.sv
// Immediate extraction and sign extension for I, S and B formats.
module sign_extend
    import risc_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_src_e    imm_src,
    output logic [31:0] imm_ext
);

    // Reassemble the immediate fields for the selected format
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            ImmI:    imm_ext = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/risc_mc_top.sv
// Multi-cycle RV32I subset core: architectural and pipeline-less holding registers
// (PC/IR/A/B/ALUOut/MDR) plus the shared ALU, register file and immediate unit.
module risc_mc_top
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        areset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic        halt,
    output logic [1:0]  fault_code
);

    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
    logic [31:0] rd1, rd2, imm_ext, alu_b, alu_result, rf_wd, pc_next;
    logic        alu_zero;
    logic        ir_we, ab_we, aluout_we, mdr_we, pc_we, pc_sel_branch;
    logic        rf_we, wb_sel_mdr, alu_src_imm;
    alu_ctrl_e   alu_ctrl;
    imm_src_e    imm_src;

    assign alu_b      = alu_src_imm ? imm_q : b_q;
    assign rf_wd      = wb_sel_mdr ? mdr_q : aluout_q;
    assign pc_next    = pc_sel_branch ? (pc_q + imm_q) : (pc_q + 32'd4);
    assign imem_addr  = pc_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;

    sign_extend u_sext (
        .instr   (ir_q[31:7]),
        .imm_src (imm_src),
        .imm_ext (imm_ext)
    );

    reg_file u_rf (
        .clk   (clk),
        .reset (areset),
        .ra1   (ir_q[19:15]),
        .ra2   (ir_q[24:20]),
        .wa    (ir_q[11:7]),
        .we    (rf_we),
        .wd    (rf_wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    alu u_alu (
        .a      (a_q),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    mc_control_fsm #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_ctrl (
        .clk           (clk),
        .areset        (areset),
        .opcode        (ir_q[6:0]),
        .funct3        (ir_q[14:12]),
        .funct7        (ir_q[31:25]),
        .alu_zero      (alu_zero),
        .alu_lsbs      (alu_result[1:0]),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .ir_we         (ir_we),
        .ab_we         (ab_we),
        .aluout_we     (aluout_we),
        .mdr_we        (mdr_we),
        .pc_we         (pc_we),
        .pc_sel_branch (pc_sel_branch),
        .rf_we         (rf_we),
        .wb_sel_mdr    (wb_sel_mdr),
        .alu_src_imm   (alu_src_imm),
        .alu_ctrl      (alu_ctrl),
        .imm_src       (imm_src),
        .retire        (retire),
        .halt          (halt),
        .fault_code    (fault_code)
    );

    // Holding registers, each loaded only by its own strobe
    always_ff @(posedge clk) begin
        if (areset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (pc_we)     pc_q     <= pc_next;
            if (ir_we)     ir_q     <= imem_rdata;
            if (ab_we) begin
                a_q   <= rd1;
                b_q   <= rd2;
                imm_q <= imm_ext;
            end
            if (aluout_we) aluout_q <= alu_result;
            if (mdr_we)    mdr_q    <= dmem_rdata;
        end
    end

endmodule

// File: doc/risc_mc_top.md
RISC_MC_TOP -- requirements
Module: risc_mc_top

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_WAIT_MAX, default 16, wait cycles tolerated per memory request before fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction fetch request; imem_addr  output  32  byte address (word-aligned).
REQ-006 imem_ready  input  1  fetch data valid; imem_rdata  input  32  instruction word.
REQ-007 dmem_req  output  1  data request; dmem_we  output  1  1=store, 0=load.
REQ-008 dmem_addr  output  32  byte address; dmem_wdata  output  32  store data.
REQ-009 dmem_ready  input  1  access complete; dmem_rdata  input  32  load data.
REQ-010 retire  output  1  one-cycle pulse per completed instruction.
REQ-011 halt  output  1  core stopped (illegal instruction or memory timeout).
REQ-012 fault_code  output  2  00 none, 01 illegal opcode/funct, 10 imem timeout, 11 dmem timeout.

Function
REQ-013 Multi-cycle RV32I subset: add, sub, and, or, slt; addi, andi, ori, slti; lw; sw; beq, bne, blt.
REQ-014 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT; exactly one active.
REQ-015 FETCH: imem_req=1, imem_addr=PC, held stable until imem_ready sampled 1; then IR<=imem_rdata, -> DECODE.
REQ-016 DECODE: read rs1/rs2 into A/B registers, latch ImmExt; illegal op/funct3/funct7 -> HALT, fault_code=01.
REQ-017 EXEC: ALU result latched into ALUOut; R/I-type -> WB; lw/sw -> MEM; branch resolves here, -> FETCH.
REQ-018 Branch: taken if beq&Zero, bne&!Zero, blt&(signed A<B); PC<=PC+ImmExt when taken, else PC+4; retire=1.
REQ-019 MEM: dmem_req=1, dmem_addr=ALUOut, dmem_wdata=B, dmem_we per op, held stable until dmem_ready=1.
REQ-020 MEM complete: sw -> FETCH with PC+4, retire=1; lw -> WB with MDR<=dmem_rdata.
REQ-021 WB: rd<=ALUOut (ALU ops) or MDR (lw); write to x0 discarded; PC<=PC+4; retire=1; -> FETCH.
REQ-022 Zero-wait latency: branch 3 cycles, ALU op 4, sw 4, lw 5; each wait cycle adds one.
REQ-023 Wait counter counts cycles with req=1 and ready=0; reaching MEM_WAIT_MAX -> HALT, fault_code 10/11.
REQ-024 HALT: halt=1, imem_req=0, dmem_req=0, no register/PC writes, retire=0; exit only by reset.
REQ-025 Arithmetic 32-bit, wrap-around, no overflow trap; slt/blt signed; PC wraps modulo 2^32.
REQ-026 ready asserted while req=0 ignored; req deasserted cycle after ready sampled 1.
REQ-027 Misaligned lw/sw address (bits[1:0]!=0) treated as illegal -> HALT, fault_code=01, no dmem_req.

Reset
REQ-028 areset=1 at a clock edge: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, wait counter=0.
REQ-029 Reset values: imem_req=0 during reset, dmem_req=0, dmem_we=0, retire=0, halt=0, fault_code=00.
REQ-030 All 32 registers cleared on reset; reset mid-request aborts it, no write of pending data.

Structure
REQ-031 Package risc_pkg holds opcode/funct constants, FSM state encoding, ALUControl codes, fault codes.
REQ-032 Existing alu, reg_file, sign_extend reused unchanged; PC/IR/A/B/ALUOut/MDR in top.
REQ-033 One sub-module mc_control_fsm: state register, wait counter, decode, all control strobes.

Verification
REQ-034 Program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2, zero-wait -> x3=12, retire pulses at cycles 4,8,12.
REQ-035 sw x3,8(x0) then lw x4,8(x0), dmem_ready delayed 3 cycles -> x4=12, lw completes in 8 cycles, signals stable while waiting.
REQ-036 blt x1,x2,+8 with x1=-1, x2=1 -> PC advances by 8; bne with equal operands -> PC+4; 3 cycles each.
REQ-037 Opcode 7'h7F fetched -> halt=1, fault_code=01, no further imem_req; areset -> PC=RESET_PC, halt=0.
REQ-038 imem_ready held 0 with MEM_WAIT_MAX=4 -> halt after 4 wait cycles, fault_code=10.
REQ-039 addi x0,x0,9 then add x5,x0,x0 -> x5=0; areset asserted during lw MEM wait -> x rd unchanged (0).
